// File: rtl/output_ts_restore_pkg.sv
// Shared constants, FSM encoding and the byte-wide CRC-8 step for the TS restorer.
package output_ts_restore_pkg;

   localparam int         TS_PKT_LEN = 188;
   localparam logic [7:0] TS_SYNC    = 8'h47;
   localparam logic [7:0] CRC8_POLY  = 8'hD5;
   localparam logic [7:0] LAST_IDX   = 8'(TS_PKT_LEN - 1);

   typedef enum logic [1:0] {
      ST_SEEK     = 2'd0,
      ST_SYNC_OUT = 2'd1,
      ST_DATA_OUT = 2'd2
   } state_e;

   // MSB-first CRC-8 over one byte
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
      logic [7:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
         else             c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/ts_crc8_calc.sv
// Running CRC-8 register; init restarts the sum from zero with the current byte.
module ts_crc8_calc
   import output_ts_restore_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       init,
   input  logic [7:0] d,
   output logic [7:0] crc
);

   logic [7:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (ena) crc_d = crc8_byte(init ? 8'h00 : crc_q, d);
   end

   always_ff @(posedge clk) begin
      if (!rst) crc_q <= 8'h00;
      else      crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/output_ts_restore.sv
// Rebuilds a 188-byte TS stream from an indexed byte FIFO, re-inserting the sync
// byte and (in NM) checking the CRC-8 carried at index 0 against the prior packet.
module output_ts_restore
   import output_ts_restore_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = TS_SYNC,
   parameter int         ERR_CNT_W = 16
) (
   input  logic                 DCLK,
   input  logic                 RST,
   input  logic                 nm_or_hem,
   input  logic                 EMPTY,
   input  logic [7:0]           DATA_IN,
   input  logic [7:0]           BYTE_INDEX_IN,
   output logic                 RD_REQ,
   output logic [7:0]           DATA_OUT,
   output logic                 DVALID_OUT,
   output logic                 PSYNC_OUT,
   output logic                 LOCKED,
   output logic                 CRC_ERR,
   output logic [ERR_CNT_W-1:0] CRC_ERR_CNT
);

   state_e                 state_q, state_d;
   logic                   run_q, run_d, rd_pend_q, rd_pend_d, mode_q, mode_d;
   logic [7:0]             exp_q, exp_d, hold_q, hold_d, dout_q, dout_d;
   logic                   hold_v_q, hold_v_d, dval_q, dval_d, psync_q, psync_d;
   logic                   locked_q, locked_d, crc_err_q, crc_err_d, first_q, first_d;
   logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   crc_ena, crc_init;
   logic [7:0]             crc_val, idx_next;

   ts_crc8_calc u_crc (
      .clk (DCLK),
      .rst (RST),
      .ena (crc_ena),
      .init(crc_init),
      .d   (DATA_IN),
      .crc (crc_val)
   );

   // run_q keeps RD_REQ low on the first cycle after reset
   assign RD_REQ = run_q && !EMPTY &&
                   (state_q == ST_SEEK || (state_q == ST_DATA_OUT && !hold_v_q));

   assign idx_next = (BYTE_INDEX_IN == LAST_IDX) ? (nm_or_hem ? 8'd1 : 8'd0)
                                                 : BYTE_INDEX_IN + 8'd1;

   always_comb begin
      state_d   = state_q;
      run_d     = 1'b1;
      rd_pend_d = RD_REQ;
      mode_d    = nm_or_hem;
      exp_d     = exp_q;
      hold_d    = hold_q;
      hold_v_d  = hold_v_q;
      dout_d    = dout_q;
      dval_d    = 1'b0;
      psync_d   = 1'b0;
      locked_d  = locked_q;
      crc_err_d = 1'b0;
      first_d   = first_q;
      cnt_d     = cnt_q;
      crc_ena   = 1'b0;
      crc_init  = 1'b0;

      if (state_q != ST_SEEK && nm_or_hem != mode_q) begin
         state_d  = ST_SEEK;
         locked_d = 1'b0;
         hold_v_d = 1'b0;
         first_d  = 1'b1;
      end else begin
         case (state_q)
            ST_SEEK: begin
               if (rd_pend_q && !nm_or_hem && BYTE_INDEX_IN == 8'd0) begin
                  {dout_d, dval_d, psync_d} = {SYNC_BYTE, 2'b11};
                  locked_d = 1'b1;
                  exp_d    = 8'd1;
                  first_d  = 1'b1;
                  state_d  = ST_DATA_OUT;
               end else if (rd_pend_q && nm_or_hem && BYTE_INDEX_IN == 8'd1) begin
                  {dout_d, dval_d, psync_d} = {SYNC_BYTE, 2'b11};
                  hold_d   = DATA_IN;
                  hold_v_d = 1'b1;
                  locked_d = 1'b1;
                  exp_d    = 8'd2;
                  crc_ena  = 1'b1;
                  crc_init = 1'b1;
                  state_d  = ST_SYNC_OUT;
               end
            end
            // Sync is on the output now; release the held byte and park any
            // byte that was already in flight when the sync was inserted.
            ST_SYNC_OUT: begin
               {dout_d, dval_d} = {hold_q, 1'b1};
               hold_v_d = 1'b0;
               state_d  = ST_DATA_OUT;
               if (rd_pend_q) begin
                  if (BYTE_INDEX_IN == exp_q) begin
                     hold_d   = DATA_IN;
                     hold_v_d = 1'b1;
                     exp_d    = idx_next;
                     crc_ena  = 1'b1;
                  end else begin
                     state_d  = ST_SEEK;
                     locked_d = 1'b0;
                     first_d  = 1'b1;
                  end
               end
            end
            ST_DATA_OUT: begin
               if (hold_v_q) begin
                  {dout_d, dval_d} = {hold_q, 1'b1};
                  hold_v_d = 1'b0;
               end else if (rd_pend_q) begin
                  if (BYTE_INDEX_IN != exp_q) begin
                     state_d  = ST_SEEK;
                     locked_d = 1'b0;
                     first_d  = 1'b1;
                  end else if (BYTE_INDEX_IN == 8'd0) begin
                     {dout_d, dval_d, psync_d} = {SYNC_BYTE, 2'b11};
                     crc_err_d = !first_q && (DATA_IN != crc_val);
                     exp_d     = 8'd1;
                  end else if (nm_or_hem && BYTE_INDEX_IN == 8'd1) begin
                     {dout_d, dval_d, psync_d} = {SYNC_BYTE, 2'b11};
                     hold_d   = DATA_IN;
                     hold_v_d = 1'b1;
                     exp_d    = 8'd2;
                     crc_ena  = 1'b1;
                     crc_init = 1'b1;
                     state_d  = ST_SYNC_OUT;
                  end else begin
                     {dout_d, dval_d} = {DATA_IN, 1'b1};
                     exp_d    = idx_next;
                     crc_ena  = 1'b1;
                     crc_init = (BYTE_INDEX_IN == 8'd1);
                     if (BYTE_INDEX_IN == LAST_IDX) first_d = 1'b0;
                  end
               end
            end
            default: state_d = ST_SEEK;
         endcase
      end

      if (crc_err_d && cnt_q != '1) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge DCLK) begin
      if (!RST) begin
         state_q   <= ST_SEEK;
         run_q     <= 1'b0;
         rd_pend_q <= 1'b0;
         mode_q    <= 1'b0;
         exp_q     <= 8'd0;
         hold_q    <= 8'd0;
         hold_v_q  <= 1'b0;
         dout_q    <= 8'd0;
         dval_q    <= 1'b0;
         psync_q   <= 1'b0;
         locked_q  <= 1'b0;
         crc_err_q <= 1'b0;
         first_q   <= 1'b1;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         rd_pend_q <= rd_pend_d;
         mode_q    <= mode_d;
         exp_q     <= exp_d;
         hold_q    <= hold_d;
         hold_v_q  <= hold_v_d;
         dout_q    <= dout_d;
         dval_q    <= dval_d;
         psync_q   <= psync_d;
         locked_q  <= locked_d;
         crc_err_q <= crc_err_d;
         first_q   <= first_d;
         cnt_q     <= cnt_d;
      end
   end

   assign DATA_OUT    = dout_q;
   assign DVALID_OUT  = dval_q;
   assign PSYNC_OUT   = psync_q;
   assign LOCKED      = locked_q;
   assign CRC_ERR     = crc_err_q;
   assign CRC_ERR_CNT = cnt_q;

endmodule

// File: tb/tb_output_ts_restore.sv
// Directed scenarios with random payloads and random FIFO stalls, checked
// against a packet-level reference model of the restored TS stream.
module tb_output_ts_restore;

   logic        DCLK = 1'b0, RST = 1'b0, nm_or_hem = 1'b0, EMPTY = 1'b1;
   logic [7:0]  DATA_IN = 8'h00, BYTE_INDEX_IN = 8'h00;
   logic        RD_REQ, DVALID_OUT, PSYNC_OUT, LOCKED, CRC_ERR;
   logic [7:0]  DATA_OUT;
   logic [15:0] CRC_ERR_CNT;

   output_ts_restore #(.SYNC_BYTE(8'h47), .ERR_CNT_W(16)) dut (
      .DCLK(DCLK), .RST(RST), .nm_or_hem(nm_or_hem), .EMPTY(EMPTY),
      .DATA_IN(DATA_IN), .BYTE_INDEX_IN(BYTE_INDEX_IN), .RD_REQ(RD_REQ),
      .DATA_OUT(DATA_OUT), .DVALID_OUT(DVALID_OUT), .PSYNC_OUT(PSYNC_OUT),
      .LOCKED(LOCKED), .CRC_ERR(CRC_ERR), .CRC_ERR_CNT(CRC_ERR_CNT)
   );

   always #5 DCLK = ~DCLK;

   typedef struct { logic [7:0] idx; logic [7:0] d; } in_t;
   typedef struct { logic [7:0] d; logic ps; logic err; } out_t;

   in_t        in_q[$];
   out_t       exp_q[$];
   int         checks = 0, failures = 0;
   int         n_exp, out_cnt, err_pulses;
   bit         saw_unlock;
   logic [7:0] run_crc = 8'h00, pkt_crc = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // CRC-8 as polynomial division: fold the byte in, then 8 shift/reduce steps
   function automatic logic [7:0] ref_crc(input logic [7:0] crc, input logic [7:0] d);
      logic [8:0] x;
      x = {1'b0, crc ^ d};
      repeat (8) begin
         x = x << 1;
         if (x[8]) x = x ^ 9'h1D5;
      end
      return x[7:0];
   endfunction

   // b0mode: 0 = correct CRC of previous packet, 1 = corrupted, 2 = random
   function automatic void add_range(input bit hem, input int lo, input int hi,
                                     input int b0mode, input int skip);
      logic [7:0] d;
      for (int i = lo; i <= hi; i++) begin
         if (i == skip || (hem && i == 0)) continue;
         if (i == 0) begin
            d = (b0mode == 0) ? pkt_crc : (b0mode == 1) ? (pkt_crc ^ 8'h5A) : 8'($urandom);
         end else begin
            d = 8'($urandom);
            if (i == 1) run_crc = 8'h00;
            run_crc = ref_crc(run_crc, d);
            if (i == 187) pkt_crc = run_crc;
         end
         in_q.push_back('{8'(i), d});
      end
   endfunction

   function automatic void push_out(input logic [7:0] d, input bit ps, input bit err);
      exp_q.push_back('{d, ps, err});
   endfunction

   // Expected output stream from the input byte sequence, packet rules only
   function automatic void build_model(input bit hem);
      bit lk = 0, have = 0;
      int ex = 0;
      logic [7:0] crc = 8'h00;
      exp_q.delete();
      foreach (in_q[k]) begin
         int i;
         logic [7:0] d;
         i = int'(in_q[k].idx);
         d = in_q[k].d;
         if (!lk) begin
            if (!hem && i == 0) begin
               push_out(8'h47, 1, 0); lk = 1; ex = 1; have = 0;
            end else if (hem && i == 1) begin
               push_out(8'h47, 1, 0); push_out(d, 0, 0);
               crc = ref_crc(8'h00, d); lk = 1; ex = 2;
            end
         end else if (i != ex) begin
            lk = 0; have = 0;
         end else begin
            if (i == 0) push_out(8'h47, 1, have && (d != crc));
            else begin
               if (i == 1) crc = 8'h00;
               if (hem && i == 1) push_out(8'h47, 1, 0);
               push_out(d, 0, 0);
               crc = ref_crc(crc, d);
               if (i == 187) have = 1;
            end
            ex = (i == 187) ? (hem ? 1 : 0) : i + 1;
         end
      end
   endfunction

   task automatic do_reset(input string tag);
      RST = 1'b0; EMPTY = 1'b0;
      @(posedge DCLK); @(negedge DCLK);
      chk({tag, "_rst_rd_req"}, RD_REQ, 0);
      chk({tag, "_rst_data"}, DATA_OUT, 0);
      chk({tag, "_rst_dvalid"}, DVALID_OUT, 0);
      chk({tag, "_rst_psync"}, PSYNC_OUT, 0);
      chk({tag, "_rst_locked"}, LOCKED, 0);
      chk({tag, "_rst_crc_err"}, CRC_ERR, 0);
      chk({tag, "_rst_cnt"}, CRC_ERR_CNT, 0);
      @(posedge DCLK); #1;
      RST = 1'b1; EMPTY = 1'b1;
   endtask

   task automatic run_stream(input bit hem, input int stall_pct, input string tag);
      out_t e;
      bit   rd_s, was_locked = 0;
      int   idle = 0;
      build_model(hem);
      n_exp = exp_q.size(); out_cnt = 0; err_pulses = 0; saw_unlock = 0;
      rd_s = RD_REQ;
      for (int cyc = 0; cyc < 6000 && idle < 30; cyc++) begin
         @(posedge DCLK); #1;
         if (rd_s && in_q.size() > 0) begin
            DATA_IN = in_q[0].d; BYTE_INDEX_IN = in_q[0].idx;
            void'(in_q.pop_front());
         end else begin
            DATA_IN = 8'($urandom); BYTE_INDEX_IN = 8'($urandom);
         end
         EMPTY = (in_q.size() == 0) || ($urandom_range(99) < stall_pct);
         if (in_q.size() == 0) idle++;
         @(negedge DCLK);
         if (CRC_ERR) err_pulses++;
         if (LOCKED) was_locked = 1; else if (was_locked) saw_unlock = 1;
         if (DVALID_OUT) begin
            out_cnt++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk({tag, "_data"}, DATA_OUT, e.d);
               chk({tag, "_psync"}, PSYNC_OUT, e.ps);
               chk({tag, "_crc_err"}, CRC_ERR, e.err);
            end
         end else chk({tag, "_crc_err_idle"}, CRC_ERR, 0);
         chk({tag, "_rd_when_empty"}, RD_REQ & EMPTY, 0);
         rd_s = RD_REQ;
      end
      chk({tag, "_out_count"}, out_cnt, n_exp);
      chk({tag, "_in_left"}, in_q.size(), 0);
   endtask

   initial begin
      // NM, three clean packets
      nm_or_hem = 1'b0; in_q.delete(); do_reset("nm3");
      add_range(0, 0, 187, 2, -1); add_range(0, 0, 187, 0, -1); add_range(0, 0, 187, 0, -1);
      run_stream(0, 0, "nm3");
      chk("nm3_err_pulses", err_pulses, 0);
      chk("nm3_cnt", CRC_ERR_CNT, 0);
      chk("nm3_locked", LOCKED, 1);

      // NM, packet 3 carries a bad CRC byte
      in_q.delete(); do_reset("nmbad");
      add_range(0, 0, 187, 2, -1); add_range(0, 0, 187, 0, -1); add_range(0, 0, 187, 1, -1);
      run_stream(0, 0, "nmbad");
      chk("nmbad_err_pulses", err_pulses, 1);
      chk("nmbad_cnt", CRC_ERR_CNT, 1);

      // HEM, two packets
      nm_or_hem = 1'b1; in_q.delete(); do_reset("hem2");
      add_range(1, 1, 187, 0, -1); add_range(1, 1, 187, 0, -1);
      run_stream(1, 0, "hem2");
      chk("hem2_locked", LOCKED, 1);

      // NM index jump 50->52, relock with a bogus (unchecked) CRC byte
      nm_or_hem = 1'b0; in_q.delete(); do_reset("jump");
      add_range(0, 0, 187, 2, -1); add_range(0, 0, 187, 0, 51);
      add_range(0, 0, 187, 1, -1); add_range(0, 0, 187, 0, -1);
      run_stream(0, 0, "jump");
      chk("jump_unlock_seen", saw_unlock, 1);
      chk("jump_cnt", CRC_ERR_CNT, 0);

      // Random FIFO stalls, NM with a bad packet 3 CRC
      in_q.delete(); do_reset("nmstall");
      add_range(0, 0, 187, 2, -1); add_range(0, 0, 187, 0, -1); add_range(0, 0, 187, 1, -1);
      run_stream(0, 40, "nmstall");
      chk("nmstall_cnt", CRC_ERR_CNT, 1);

      // Random FIFO stalls, HEM, then a mode flip must drop lock
      nm_or_hem = 1'b1; in_q.delete(); do_reset("hemstall");
      add_range(1, 1, 187, 0, -1); add_range(1, 1, 187, 0, -1); add_range(1, 1, 187, 0, -1);
      run_stream(1, 40, "hemstall");
      chk("hemstall_locked", LOCKED, 1);
      nm_or_hem = 1'b0;
      @(posedge DCLK); @(negedge DCLK);
      chk("mode_flip_unlock", LOCKED, 0);

      // Reset mid-packet at index 100, then relock on the next entry point
      in_q.delete(); do_reset("rstmid");
      add_range(0, 0, 187, 2, -1); add_range(0, 0, 100, 1, -1);
      run_stream(0, 0, "rstmid_a");
      chk("rstmid_a_cnt", CRC_ERR_CNT, 1);
      do_reset("rstmid");
      add_range(0, 101, 187, 0, -1); add_range(0, 0, 187, 1, -1); add_range(0, 0, 187, 0, -1);
      run_stream(0, 25, "rstmid_b");
      chk("rstmid_b_cnt", CRC_ERR_CNT, 0);
      chk("rstmid_b_locked", LOCKED, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/output_ts_restore.md
OUTPUT_TS_RESTORE -- requirements
Module: output_ts_restore

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h47, value inserted at TS packet byte index 0.
REQ-002 Parameter ERR_CNT_W, default 16, width of the CRC error counter.
REQ-003 Port DCLK input 1: the single clock; all logic on its rising edge.
REQ-004 Port RST input 1: synchronous, active-low reset.
REQ-005 Port nm_or_hem input 1: 0 = NM, where byte index 0 carries the CRC-8 of the previous UP; 1 = HEM, where index 0 is absent.
REQ-006 Port EMPTY input 1: upstream FIFO empty flag.
REQ-007 Port DATA_IN input 8: FIFO data; valid exactly one cycle after RD_REQ was high.
REQ-008 Port BYTE_INDEX_IN input 8: FIFO byte index, 0..187, aligned with DATA_IN.
REQ-009 Port RD_REQ output 1: FIFO read request.
REQ-010 Port DATA_OUT output 8: restored TS byte.
REQ-011 Port DVALID_OUT output 1: DATA_OUT valid strobe.
REQ-012 Port PSYNC_OUT output 1: high with the sync byte (index 0).
REQ-013 Port LOCKED output 1: high while the index sequence is contiguous.
REQ-014 Port CRC_ERR output 1: one-cycle pulse on NM CRC mismatch.
REQ-015 Port CRC_ERR_CNT output ERR_CNT_W: saturating mismatch count.

Function
REQ-016 The FSM SHALL have states SEEK, SYNC_OUT and DATA_OUT.
REQ-017 SEEK: RD_REQ = !EMPTY; fetched bytes are discarded until an entry point arrives: index 0 in NM, index 1 in HEM.
REQ-018 SEEK at the NM entry point: index-0 byte is stored as the expected CRC with no check; emit SYNC_BYTE with PSYNC_OUT=1; LOCKED=1; go to DATA_OUT.
REQ-019 SEEK at the HEM entry point: the index-1 byte is placed in a one-entry hold register; go to SYNC_OUT.
REQ-020 SYNC_OUT: emit SYNC_BYTE, DVALID_OUT=1, PSYNC_OUT=1, RD_REQ=0; next cycle emit the held byte; go to DATA_OUT.
REQ-021 DATA_OUT: RD_REQ = !EMPTY and hold register empty; each fetched byte is emitted one cycle after arrival.
REQ-022 Latency SHALL be exactly 1 cycle from DATA_IN valid to DATA_OUT, except for bytes delayed by inserted sync.
REQ-023 Expected index SHALL advance 1..187, then wrap to 0 (NM) or 1 (HEM); a wrap in HEM passes through SYNC_OUT using the hold register.
REQ-024 In NM, a received index-0 byte SHALL never be output; SYNC_BYTE is output in its place with PSYNC_OUT=1.
REQ-025 Index mismatch SHALL drop the byte, clear LOCKED and return to SEEK; there is no CRC check on that packet.
REQ-026 CRC-8: polynomial x^8+x^7+x^6+x^4+x^2+1, init 8'h00, MSB first, over indices 1..187; reinitialised at each index 1.
REQ-027 NM check: at each index-0 byte after the first locked packet, compare it with the CRC of the preceding 187 bytes; on mismatch, pulse CRC_ERR the cycle the sync is output.
REQ-028 CRC_ERR_CNT SHALL increment on each CRC_ERR and saturate at all-ones; it is cleared only by reset.
REQ-029 nm_or_hem SHALL be treated as static; a change while LOCKED forces SEEK within one cycle.
REQ-030 EMPTY mid-packet SHALL stall without loss: DVALID_OUT=0 and state held.

Reset
REQ-031 On RST=0 at a DCLK edge: state SEEK, RD_REQ=0, DATA_OUT=0, DVALID_OUT=0, PSYNC_OUT=0, LOCKED=0, CRC_ERR=0, CRC_ERR_CNT=0, hold register empty, CRC register 0, first-packet flag set.
REQ-032 Reset mid-packet SHALL abandon the packet; after release the block behaves as after power-up.

Structure
REQ-033 A shared package SHALL hold TS_PKT_LEN=188, TS_SYNC=8'h47, CRC8_POLY=8'hD5 and the FSM state encoding.
REQ-034 CRC-8 byte-wide update logic SHALL be a single sub-module, ts_crc8_calc (inputs clk, rst, ena, init, d; output crc).

Verification
REQ-035 NM: 3 packets, indices 0..187, correct CRC bytes -> 3x188 output bytes, 0x47 at index 0, CRC_ERR never pulses.
REQ-036 NM: corrupt CRC byte of packet 3 -> one CRC_ERR pulse with the sync of packet 3; CRC_ERR_CNT=1.
REQ-037 HEM: 2 packets with indices 1..187 -> 2x188 output bytes, each preceded by 0x47 with PSYNC_OUT=1.
REQ-038 Index jump 50->52 -> LOCKED falls; bytes dropped until the next entry point; the first relocked packet has no CRC check.
REQ-039 EMPTY toggled randomly in NM and HEM -> output stream identical to the no-stall case.
REQ-040 RST low at index 100 for 1 cycle -> all outputs at reset values; relock on the next entry point.
